// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RISC-V fields (I/S/B/R) into 32-bit instruction
// words, range/alignment-checks the immediate, and tags each emitted word with
// an auto-incrementing word address for loading instruction memory.
//
// Handshake (both sides): a beat moves when valid && ready on the same rising
// edge; a source holds valid and its payload stable until that edge.
// in_ready = !out_valid || out_ready, so the single output register streams
// one word per cycle without bubbles while out_ready is high.
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        err_cnt
);

  // Instruction formats
  localparam logic [1:0] FMT_I = 2'd0;
  localparam logic [1:0] FMT_S = 2'd1;
  localparam logic [1:0] FMT_B = 2'd2;
  localparam logic [1:0] FMT_R = 2'd3;

  // Rejection codes reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Signed immediate bounds
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;

  logic signed [31:0] imm_s;
  logic               range_ok_12;
  logic               range_ok_b;
  logic               align_ok_b;
  logic [1:0]         rej_code;
  logic               legal;
  logic [31:0]        packed_word;

  logic               accept;
  logic               take;
  logic               reject;
  logic               xfer;

  logic [ADDR_W-1:0]  addr_cnt;
  logic [ADDR_W-1:0]  addr_assign;

  assign imm_s = $signed(in_imm);

  // Range tests are full 32-bit signed compares so an immediate with garbage
  // in the upper bits can never alias into range.
  assign range_ok_12 = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
  assign range_ok_b  = (imm_s >= IMMB_MIN)  && (imm_s <= IMMB_MAX);
  assign align_ok_b  = ~in_imm[0];

  // Legality: range is tested before alignment, so an odd out-of-range branch
  // offset reports a range error.
  always_comb begin
    rej_code = ERR_NONE;
    case (in_fmt)
      FMT_I, FMT_S: begin
        if (!range_ok_12) rej_code = ERR_RANGE;
      end
      FMT_B: begin
        if (!range_ok_b)      rej_code = ERR_RANGE;
        else if (!align_ok_b) rej_code = ERR_ALIGN;
      end
      default: rej_code = ERR_NONE;
    endcase
  end

  assign legal = (rej_code == ERR_NONE);

  // Bit packing: exact inverse of the datapath immediate extraction.
  always_comb begin
    packed_word = 32'h0;
    case (in_fmt)
      FMT_I: packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], in_opcode};
      FMT_B: packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
      FMT_R: packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd,
                            in_opcode};
      default: packed_word = 32'h0;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = accept && legal;
  assign reject   = accept && !legal;
  assign xfer     = out_valid && out_ready;

  // A clear coinciding with an accept hands address 0 to that word.
  assign addr_assign = addr_clr ? '0 : addr_cnt;

  // Output register: load on a legal accept, drain on transfer otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_addr  <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_instr <= packed_word;
      out_addr  <= addr_assign;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Word-address counter: advances only on legal accepts, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (take) begin
      addr_cnt <= addr_assign + ADDR_W'(1);
    end else if (addr_clr) begin
      addr_cnt <= '0;
    end
  end

  // Error state: sticky flag, last code, saturating rejection count.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
      err_cnt  <= 8'h0;
    end else if (reject) begin
      err      <= 1'b1;
      err_code <= rej_code;
      if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
